// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream round-robin arbiter.
// Build option: define AXIS_ARB_PRIO_EN to give port 0 strict priority.
package axis_arb_pkg;

   // Arbiter FSM states
   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Width of the per-grant beat counter
   localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/axis_rr_pick.sv
// Wrap-around request picker: returns the first requesting port after
// last_grant, wrapping from the top port back to port 0.
// Build option: with AXIS_ARB_PRIO_EN defined, port 0 wins whenever it
// requests and the rotating search covers ports 1..NUM_PORTS-1 only.
module axis_rr_pick
   import axis_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int GRANT_W   = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [GRANT_W-1:0]   last_grant,
   output logic [GRANT_W-1:0]   grant,
   output logic                 any_req
);

   logic [NUM_PORTS-1:0] req_eff_s;
   logic [GRANT_W-1:0]   cand_s;
   logic [GRANT_W-1:0]   rr_grant_s;
   logic                 rr_found_s;
   logic                 rr_hit_s;

   // Requests that take part in the rotating search
   always_comb begin
      req_eff_s = req;
`ifdef AXIS_ARB_PRIO_EN
      req_eff_s[0] = 1'b0;
`endif
   end

   // Walk the ports starting just after last_grant; the first hit wins
   always_comb begin
      rr_grant_s = '0;
      rr_found_s = 1'b0;
      rr_hit_s   = 1'b0;
      cand_s     = '0;
      for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
         cand_s     = GRANT_W'((32'(last_grant) + off) % NUM_PORTS);
         rr_hit_s   = ~rr_found_s & req_eff_s[cand_s];
         rr_grant_s = rr_hit_s ? cand_s : rr_grant_s;
         rr_found_s = rr_found_s | rr_hit_s;
      end
   end

   // Final grant selection and request summary
   always_comb begin
`ifdef AXIS_ARB_PRIO_EN
      if (req[0]) begin
         grant = '0;
      end else begin
         grant = rr_grant_s;
      end
`else
      grant = rr_grant_s;
`endif
      any_req = |req;
   end

endmodule

// File: rtl/axis_rr_arb.sv
// AXI-Stream N:1 round-robin arbiter feeding a stream FIFO.
// One idle arbitration cycle per grant, then up to MAX_BURST beats are
// passed through combinationally from the granted port.
// Build option: define AXIS_ARB_PRIO_EN for strict port-0 priority.
module axis_rr_arb
   import axis_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DATA_WDTH = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                            axis_clk,
   input  logic                            axis_rst,
   input  logic [NUM_PORTS*DATA_WDTH-1:0]  s_axis_tdata,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   output logic [DATA_WDTH-1:0]            m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
   output logic                            busy
);

   localparam int GRANT_W = $clog2(NUM_PORTS);
   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);

   arb_state_t              state_r;
   logic [GRANT_W-1:0]      grant_r;
   logic [GRANT_W-1:0]      last_grant_r;
   logic [BEAT_CNT_W-1:0]   beat_cnt_r;

   logic [GRANT_W-1:0]      pick_grant_s;
   logic                    any_req_s;
   logic                    xfer_act_s;
   logic                    gnt_valid_s;
   logic                    beat_s;

   axis_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .GRANT_W   (GRANT_W)
   ) u_pick (
      .req        (s_axis_tvalid),
      .last_grant (last_grant_r),
      .grant      (pick_grant_s),
      .any_req    (any_req_s)
   );

   // Transfer window is closed while reset is asserted so no beat can complete
   always_comb begin
      xfer_act_s  = (state_r == XFER) && !axis_rst;
      gnt_valid_s = s_axis_tvalid[grant_r];
      beat_s      = xfer_act_s && gnt_valid_s && m_axis_tready;
   end

   // Zero-latency routing of the granted port to the master side
   always_comb begin
      s_axis_tready = '0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      if (xfer_act_s) begin
         s_axis_tready[grant_r] = m_axis_tready;
         m_axis_tdata           = s_axis_tdata[32'(grant_r)*DATA_WDTH +: DATA_WDTH];
         m_axis_tvalid          = gnt_valid_s;
      end else begin
         s_axis_tready = '0;
      end
   end

   // Status outputs
   always_comb begin
      grant_id = grant_r;
      busy     = xfer_act_s;
   end

   // Arbitration and burst-length FSM
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state_r      <= IDLE;
         grant_r      <= '0;
         last_grant_r <= GRANT_W'(NUM_PORTS - 1);
         beat_cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  grant_r    <= pick_grant_s;
                  beat_cnt_r <= '0;
                  state_r    <= XFER;
               end
            end
            XFER: begin
               if (!gnt_valid_s || (beat_s && (beat_cnt_r == LAST_BEAT))) begin
                  state_r      <= IDLE;
                  last_grant_r <= grant_r;
               end
               if (beat_s) begin
                  beat_cnt_r <= beat_cnt_r + BEAT_CNT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
